relu_maxpool: RTL and testbench

Downstream stage of the multi-filter convolution block. It consumes the packed per-filter convolution results, one output position per `conv_valid_in` pulse in raster order. It applies ReLU to each filter lane, then 2x2 / stride-2 max pooling using a half-width line buffer, and emits one packed pooled vector per 2x2 block. It feeds the next conv layer or the flatten/FC stage.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/pool_line_buf.sv | 31 +++
 rtl/relu_maxpool.sv | 121 ++++++++++++
 tb/tb_relu_maxpool.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN post-processing stages.
//   - default lane width / lane count
//   - FSM state encoding for the pooling stage
//   - relu(): zero a sign-extended lane whose sign bit is set
//   - umax(): unsigned maximum of two zero-extended lanes
// Lanes are carried at LANE_MAX_W bits inside the helpers so that any
// DATA_WIDTH up to LANE_MAX_W can share them; callers extend and truncate.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_NUM_FILTERS = 3;
    localparam int LANE_MAX_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROW_EVEN = 2'd1,
        ST_ROW_ODD  = 2'd2,
        ST_DONE     = 2'd3
    } pool_state_t;

    // Input must be sign-extended to LANE_MAX_W by the caller.
    function automatic logic [LANE_MAX_W-1:0] relu(input logic [LANE_MAX_W-1:0] lane);
        return lane[LANE_MAX_W-1] ? '0 : lane;
    endfunction

    function automatic logic [LANE_MAX_W-1:0] umax(input logic [LANE_MAX_W-1:0] a,
                                                   input logic [LANE_MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for 2x2 pooling.
// Simple dual-port storage, no reset: every entry is written on an even
// row before the following odd row reads it.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address (col/2)
//   wdata  : pairwise max of the even-row column pair
//   raddr  : read address (col/2), combinational read
//   rdata  : stored entry at raddr
module pool_line_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 / stride-2 max pooling over a raster stream of
// packed per-filter convolution results.
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_start    : restart counters/hold and begin a new frame
//   conv_in        : NUM_FILTERS signed lanes, lane f at [f*DATA_WIDTH +: DATA_WIDTH]
//   conv_valid_in  : conv_in valid this cycle (no backpressure)
//   pool_out       : pooled unsigned lanes, same packing, held between pulses
//   pool_valid     : one-cycle pulse, 1 cycle after the (odd row, odd col) input
//   frame_done     : coincides with the last pool_valid of the frame
module relu_maxpool
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] conv_in,
    input  logic                              conv_valid_in,
    output logic [NUM_FILTERS*DATA_WIDTH-1:0] pool_out,
    output logic                              pool_valid,
    output logic                              frame_done
);

    localparam int VW       = NUM_FILTERS * DATA_WIDTH;
    localparam int COL_W    = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] lanes_t;

    pool_state_t      state;
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    lanes_t           in_lanes, relu_vec, hold, pair_max, pool_max, lb_rdata;
    logic             in_frame, accept, odd_row, odd_col, last_col, last_row;
    logic [LB_AW-1:0] lb_addr;

    assign in_lanes = conv_in;

    // frame_start re-bases the current pixel at (0,0) in the same cycle,
    // so a coincident valid input is taken as the first pixel of the frame.
    assign in_frame = (state == ST_ROW_EVEN) || (state == ST_ROW_ODD);
    assign accept   = conv_valid_in && (frame_start || in_frame);
    assign cur_col  = frame_start ? '0 : col;
    assign cur_row  = frame_start ? '0 : row;
    assign odd_row  = cur_row[0];
    assign odd_col  = cur_col[0];
    assign last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    assign lb_addr  = LB_AW'(cur_col >> 1);

    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
        logic [LANE_MAX_W-1:0] in_ext;
        assign in_ext      = LANE_MAX_W'($signed(in_lanes[f]));
        assign relu_vec[f] = DATA_WIDTH'(relu(in_ext));
        assign pair_max[f] = DATA_WIDTH'(umax(LANE_MAX_W'(hold[f]), LANE_MAX_W'(relu_vec[f])));
        assign pool_max[f] = DATA_WIDTH'(umax(LANE_MAX_W'(pair_max[f]), LANE_MAX_W'(lb_rdata[f])));
    end

    // Even rows park the horizontal pair max; the odd row below reads it
    // back at the same col/2, always after it was written.
    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (VW),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept && !odd_row && odd_col),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            pool_out   <= '0;
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                state <= ST_ROW_EVEN;
                col   <= '0;
                row   <= '0;
                hold  <= '0;
            end
            if (accept) begin
                if (!odd_col) hold <= relu_vec;
                if (odd_row && odd_col) begin
                    pool_out   <= pool_max;
                    pool_valid <= 1'b1;
                    frame_done <= last_row && last_col;
                end
                if (last_col) begin
                    col <= '0;
                    if (odd_row) begin
                        state <= last_row ? ST_DONE : ST_ROW_EVEN;
                        row   <= last_row ? '0 : cur_row + ROW_W'(1);
                    end else begin
                        state <= ST_ROW_ODD;
                        row   <= cur_row + ROW_W'(1);
                    end
                end else begin
                    col <= cur_col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool (4x4 frame, 3 lanes of 8 bits).
// The reference keeps the whole frame image and pools each 2x2 block
// directly from it; expected outputs are compared every cycle.
module tb_relu_maxpool;

    localparam int DW = 8;
    localparam int NF = 3;
    localparam int W  = 4;
    localparam int H  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              conv_valid_in = 1'b0;
    logic [NF*DW-1:0]  conv_in = '0;
    logic [NF*DW-1:0]  pool_out;
    logic              pool_valid;
    logic              frame_done;

    relu_maxpool #(
        .DATA_WIDTH (DW),
        .NUM_FILTERS(NF),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .conv_in      (conv_in),
        .conv_valid_in(conv_valid_in),
        .pool_out     (pool_out),
        .pool_valid   (pool_valid),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    bit               mdl_active = 0;
    int               mdl_idx    = 0;
    logic [DW-1:0]    img [W*H][NF];
    logic [NF*DW-1:0] exp_out   = '0;
    bit               exp_valid = 0;
    bit               exp_done  = 0;

    function automatic logic [DW-1:0] relu8(input logic [DW-1:0] x);
        int sv;
        sv = $signed(x);
        return (sv < 0) ? '0 : x;
    endfunction

    // Drive one cycle of stimulus and advance the model to match.
    task automatic step(input logic [NF*DW-1:0] vec, input bit v, input bit fs);
        int r, c, p;
        logic [DW-1:0] m;
        conv_in       = vec;
        conv_valid_in = v;
        frame_start   = fs;
        @(posedge clk);
        #1;
        conv_valid_in = 1'b0;
        frame_start   = 1'b0;
        exp_valid = 0;
        exp_done  = 0;
        if (fs) begin
            mdl_active = 1;
            mdl_idx    = 0;
        end
        if (v && mdl_active) begin
            r = mdl_idx / W;
            c = mdl_idx % W;
            for (int f = 0; f < NF; f++) img[mdl_idx][f] = relu8(vec[f*DW +: DW]);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                for (int f = 0; f < NF; f++) begin
                    m = 0;
                    for (int dr = -1; dr <= 0; dr++)
                        for (int dc = -1; dc <= 0; dc++) begin
                            p = (r + dr) * W + (c + dc);
                            if (img[p][f] > m) m = img[p][f];
                        end
                    exp_out[f*DW +: DW] = m;
                end
                exp_valid = 1;
                exp_done  = (mdl_idx == W*H-1);
            end
            mdl_idx++;
            if (mdl_idx == W*H) mdl_active = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({pool_valid, frame_done, pool_out} !== '0)
            $display("FAIL reset_state got v=%b d=%b out=%h want all 0", pool_valid, frame_done, pool_out);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // IDLE ignores inputs until frame_start
        for (int i = 0; i < 6; i++) begin
            step(24'h050505, 1'b1, 1'b0);
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL idle_ignore cyc%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         i, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] got [$];
        logic [DW-1:0] want [4];
        want = '{8'd5, 8'd7, 8'd13, 8'd15};
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < W*H; i++) begin
            step({8'hFD, 8'h80, 8'(i)}, 1'b1, 1'b0);
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL ramp px%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         i, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
            if (pool_valid) got.push_back(pool_out[DW-1:0]);
        end
        n_total++;
        if (got.size() != 4)
            $display("FAIL ramp_count got %0d pulses want 4", got.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (got[k] !== want[k])
                    $display("FAIL ramp_value%0d got %0d want %0d", k, got[k], want[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_negative();
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < W*H; i++) begin
            step({NF{8'hFD}}, 1'b1, 1'b0);
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL negative px%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         i, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_sparse();
        int i;
        i = 0;
        // frame_start coincident with the first pixel
        step({8'($urandom), 8'($urandom), 8'd0}, 1'b1, 1'b1);
        i = 1;
        for (int cyc = 0; cyc < 2*W*H && i < W*H; cyc++) begin
            bit v;
            v = cyc[0];
            step({8'($urandom), 8'($urandom), 8'(i)}, v, 1'b0);
            if (v) i++;
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL sparse cyc%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         cyc, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 6 + 1 + W*H + 4; i++) begin
            if (i < 6)               step({3{8'h7E}}, 1'b1, 1'b0);
            else if (i == 6)         step('0, 1'b0, 1'b1);
            else if (i < 7 + W*H)    step({8'h00, 8'h00, 8'(i-7)}, 1'b1, 1'b0);
            else                     step({3{8'h7F}}, 1'b1, 1'b0);
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL abort cyc%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         i, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(NF*DW'($urandom), 1'b1, 1'b0);
        // last step pooled block (1,1): outputs are live right now
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pool_valid, frame_done, pool_out} !== '0)
            $display("FAIL reset_mid got v=%b d=%b out=%h want all 0", pool_valid, frame_done, pool_out);
        else n_pass++;
        mdl_active = 0;
        exp_out    = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 + 1 + W*H; i++) begin
            if (i < 4)       step(NF*DW'($urandom), 1'b1, 1'b0);
            else if (i == 4) step(NF*DW'($urandom), 1'b1, 1'b1);
            else             step(NF*DW'($urandom), 1'b1, 1'b0);
            n_total++;
            if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                $display("FAIL after_reset cyc%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                         i, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int fr = 0; fr < 6; fr++) begin
            int cyc;
            bit fs_with_px;
            fs_with_px = ($urandom_range(0, 1) == 1);
            step(NF*DW'($urandom), fs_with_px, 1'b1);
            cyc = 0;
            while (mdl_active && cyc < 200) begin
                step(NF*DW'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
                cyc++;
                n_total++;
                if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                    $display("FAIL random f%0d c%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                             fr, cyc, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
                else n_pass++;
            end
            // trailing inputs after the frame end are ignored
            for (int k = 0; k < 3; k++) begin
                step(NF*DW'($urandom), 1'b1, 1'b0);
                n_total++;
                if ({pool_valid, frame_done, pool_out} !== {exp_valid, exp_done, exp_out})
                    $display("FAIL random_tail f%0d k%0d got v=%b d=%b out=%h want v=%b d=%b out=%h",
                             fr, k, pool_valid, frame_done, pool_out, exp_valid, exp_done, exp_out);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_sparse();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
